// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI RAM slave: frames a 10-bit command MSB first on mosi/ss_n
// and, for rd-data commands, captures the returned byte from miso.
module spi_master_ctrl #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_word,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [9:0]  shreg;
  logic [7:0]  rx_sh;
  logic        is_read;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = ST_CMD;
          cnt_next   = '0;
        end
      end
      ST_CMD: begin
        state_next = ST_SHIFT;
        cnt_next   = '0;
      end
      ST_SHIFT: begin
        if (cnt == 4'd9) begin
          cnt_next = '0;
          if (is_read)
            state_next = (RD_LATENCY == 0) ? ST_RECV : ST_WAIT;
          else
            state_next = ST_GAP;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt == LAT_LAST) begin
          state_next = ST_RECV;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ST_RECV: begin
        if (cnt == 4'd7) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pin outputs are registered from next-state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      rx_sh    <= '0;
      is_read  <= 1'b0;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ss_n     <= (state_next == ST_IDLE) || (state_next == ST_GAP);
      mosi     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            shreg   <= cmd_word;
            is_read <= &cmd_word[9:8];
            mosi    <= cmd_word[9];
          end
        end
        ST_CMD: mosi <= shreg[9];
        ST_SHIFT: begin
          shreg <= {shreg[8:0], 1'b0};
          if (cnt != 4'd9) mosi <= shreg[8];
        end
        ST_RECV: begin
          rx_sh <= {rx_sh[6:0], miso};
          if (cnt == 4'd7) begin
            rd_data  <= {rx_sh[6:0], miso};
            rd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised bench for spi_master_ctrl: a frame-timing reference model predicts
// every pin each cycle from the accept edge and the command word.
module tb_spi_master_ctrl;

  localparam int L = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_word = '0;
  logic       miso = 1'b0;
  logic       cmd_ready, ss_n, mosi, rd_valid, busy;
  logic [7:0] rd_data;

  spi_master_ctrl #(.RD_LATENCY(L), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         n_edge = 0;
  int         a = 0;
  int         k = 0;
  bit         in_frame = 0;
  bit         frm_rd = 0;
  bit         acc = 0;
  bit         m_ready = 1;
  logic [9:0] m_word = '0;
  logic [7:0] m_byte = '0;
  logic [7:0] e_rd_data = '0;
  logic       e_ss = 1'b1, e_mosi = 1'b0, e_rdv = 1'b0;
  bit         force_en = 0;
  logic [7:0] force_byte = '0;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  task automatic model_edge();
    int f;
    n_edge++;
    acc = 0;
    if (!rst_n) begin
      in_frame  = 0;
      m_ready   = 1;
      e_ss      = 1'b1;
      e_mosi    = 1'b0;
      e_rdv     = 1'b0;
      e_rd_data = '0;
      return;
    end
    if (cmd_valid && m_ready) begin
      acc      = 1;
      a        = n_edge;
      m_word   = cmd_word;
      frm_rd   = (cmd_word[9:8] == 2'b11);
      m_byte   = force_en ? force_byte : 8'($urandom);
      in_frame = 1;
    end
    if (in_frame) begin
      k  = n_edge - a;
      f  = frm_rd ? 19 + L : 11;
      e_ss   = (k >= f);
      if (k == 0)       e_mosi = m_word[9];
      else if (k <= 10) e_mosi = m_word[10 - k];
      else              e_mosi = 1'b0;
      e_rdv  = frm_rd && (k == f);
      if (e_rdv) e_rd_data = m_byte;
      m_ready = (k >= f + G);
    end else begin
      e_ss    = 1'b1;
      e_mosi  = 1'b0;
      e_rdv   = 1'b0;
      m_ready = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ss_n", 10'(ss_n), 10'(e_ss));
    check("mosi", 10'(mosi), 10'(e_mosi));
    check("rd_valid", 10'(rd_valid), 10'(e_rdv));
    check("rd_data", 10'(rd_data), 10'(e_rd_data));
    check("cmd_ready", 10'(cmd_ready), 10'(m_ready));
    check("busy", 10'(busy), 10'(!m_ready));
    // slave returns bit i so that it is sampled on edge a+12+L+i
    if (in_frame && frm_rd && k >= 11 + L && k <= 18 + L)
      miso = m_byte[7 - (k - 11 - L)];
    else
      miso = 1'($urandom);
  endtask

  task automatic send(input logic [9:0] w, input bit hold);
    cmd_valid = 1'b1;
    cmd_word  = w;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc) break;
    end
    check("accept", 10'(acc), 10'd1);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_word  = 10'($urandom);
    end
  endtask

  task automatic idle_until_ready();
    for (int i = 0; i < 100 && !m_ready; i++) tick();
    tick();
  endtask

  initial begin
    int hi_cnt;
    // reset held with cmd_valid asserted
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_word  = 10'h3FF;
    for (int i = 0; i < 5; i++) tick();
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();

    // write addr
    send(10'h0A5, 0);
    idle_until_ready();

    // read data, slave returns C3
    force_en   = 1;
    force_byte = 8'hC3;
    send(10'h300, 0);
    idle_until_ready();
    check("rd_data_c3", 10'(rd_data), 10'h0C3);
    force_en = 0;

    // back-to-back with cmd_valid held
    send(10'h012, 1);
    hi_cnt = 0;
    cmd_word = 10'h134;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc) break;
      if (ss_n) hi_cnt++;
    end
    check("accept2", 10'(acc), 10'd1);
    check("gap_len", 10'(hi_cnt), 10'(G + 1));
    cmd_valid = 1'b0;
    idle_until_ready();

    // reset during RECV at the 4th miso bit
    send(10'h3A5, 0);
    for (int i = 0; i < 100 && !(in_frame && k == 11 + L + 3); i++) tick();
    check("reach_recv", 10'(k), 10'(11 + L + 3));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("ss_n_abort", 10'(ss_n), 10'd1);
    check("rd_data_abort", 10'(rd_data), 10'd0);
    for (int i = 0; i < 30; i++) tick();

    // command pulsed during SHIFT is ignored
    send(10'h100, 0);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_word  = 10'h3FF;
    tick();
    cmd_valid = 1'b0;
    idle_until_ready();

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_word  = 10'($urandom);
      tick();
    end
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
